// File: rtl/linebuffer_window9.sv
// Streaming K-row line buffer producing a KxK sliding pixel window per accepted pixel,
// with a single registered output slot and valid/ready flow control on both sides.
module linebuffer_window9 #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned K     = 9,
    parameter int unsigned PIX_W = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIX_W-1:0]       pix_in,
    input  logic                   pix_valid,
    input  logic                   pix_sof,
    output logic                   pix_ready,
    output logic [K*K*PIX_W-1:0]   win_data,
    output logic                   win_valid,
    output logic                   win_last,
    input  logic                   win_ready
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    logic [CW-1:0]    col_q, col_d, cur_col;
    logic [RW-1:0]    row_q, row_d, cur_row;
    logic             win_valid_q, win_last_q;
    logic             accept, emit, at_end;
    logic [PIX_W-1:0] new_col [K];
    logic [PIX_W-1:0] win_q   [K][K];
    // line_mem[i] holds image row (cur_row - 1 - i)
    logic [PIX_W-1:0] line_mem [K-1][IMG_W];

    assign pix_ready = !win_valid_q || win_ready;
    assign accept    = pix_valid && pix_ready;
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;

    always_comb begin
        cur_col = pix_sof ? '0 : col_q;
        cur_row = pix_sof ? '0 : row_q;
        emit    = accept && (cur_row >= RW'(K - 1)) && (cur_col >= CW'(K - 1));
        at_end  = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
        if (cur_col == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
        end else begin
            col_d = cur_col + 1'b1;
            row_d = cur_row;
        end
    end

    always_comb begin
        for (int r = 0; r < int'(K); r++) begin
            new_col[r] = '0;
        end
        new_col[K-1] = pix_in;
        for (int i = 0; i < int'(K) - 1; i++) begin
            new_col[int'(K) - 2 - i] = line_mem[i][cur_col];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            line_mem[0][cur_col] <= pix_in;
            for (int i = 1; i < int'(K) - 1; i++) begin
                line_mem[i][cur_col] <= line_mem[i-1][cur_col];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            for (int r = 0; r < int'(K); r++) begin
                for (int c = 0; c < int'(K); c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            if (accept) begin
                col_q <= col_d;
                row_q <= row_d;
                for (int r = 0; r < int'(K); r++) begin
                    for (int c = 0; c < int'(K) - 1; c++) begin
                        win_q[r][c] <= win_q[r][c+1];
                    end
                    win_q[r][K-1] <= new_col[r];
                end
            end
            if (emit) begin
                win_valid_q <= 1'b1;
                win_last_q  <= at_end;
            end else if (win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int r = 0; r < int'(K); r++) begin
            for (int c = 0; c < int'(K); c++) begin
                win_data[(r*int'(K) + c)*int'(PIX_W) +: PIX_W] = win_q[r][c];
            end
        end
    end

endmodule
